acc_filter: RTL
===============

ACC_FILTER -- requirements
Module: acc_filter

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high global reset.
REQ-004 filter_rst  input  1  synchronous, active-high filter flush; clears history without a global reset.
REQ-005 sample_valid  input  1  one-cycle pulse marking a new x/y/z triple; driven by the accelerometer interface's done_read.
REQ-006 x_in, y_in, z_in  input  16 each  signed two's-complement raw axis samples; sampled only when sample_valid=1.
REQ-007 x_out, y_out, z_out  output  16 each  signed moving-average result per axis, registered.
REQ-008 out_valid  output  1  one-cycle pulse when x_out/y_out/z_out update.
REQ-009 primed  output  1  high once the window holds DEPTH real samples since the last reset or flush.
REQ-010 DEPTH  parameter, default 8  window length; power of two, 2..64.

Function
REQ-011 Each axis SHALL keep a DEPTH-entry circular history, a write pointer (LOG2_DEPTH bits, wraps DEPTH-1 -> 0) and a signed running sum of width SUM_W = 16 + LOG2_DEPTH.
REQ-012 On sample_valid: sum <= sum + in - hist[wr_ptr]; hist[wr_ptr] <= in; wr_ptr <= wr_ptr + 1.
REQ-013 Output SHALL be (new sum) arithmetic-right-shifted by LOG2_DEPTH, i.e. floor division, registered into x_out/y_out/z_out.
REQ-014 Latency SHALL be exactly 1 cycle: sample_valid at edge N -> outputs and out_valid=1 visible after edge N+1; out_valid is low in every cycle without a preceding sample_valid.
REQ-015 Back-to-back sample_valid on consecutive cycles SHALL be accepted with no loss; there is no back-pressure.
REQ-016 Empty history entries SHALL read as 0, so outputs during fill equal (sum of samples so far) >>> LOG2_DEPTH.
REQ-017 The control FSM SHALL have two states: FILL (primed=0, fill counter counts accepted samples) and RUN (primed=1).
REQ-018 The FSM SHALL transition FILL -> RUN on the sample_valid that makes the fill count equal DEPTH; RUN persists until rst or filter_rst.
REQ-019 primed SHALL rise in the same cycle as the out_valid of the DEPTH-th sample.
REQ-020 The running sum SHALL never overflow: SUM_W holds DEPTH * (-32768) .. DEPTH * 32767; the result after the shift fits in 16 bits with no saturation.
REQ-021 If filter_rst and sample_valid occur in the same cycle, filter_rst SHALL win and the sample SHALL be discarded (no out_valid next cycle).
REQ-022 Outputs SHALL hold their last value between out_valid pulses.

Reset
REQ-023 rst or filter_rst SHALL set: history entries = 0, sums = 0, wr_ptr = 0, fill count = 0, state = FILL, x_out/y_out/z_out = 0, out_valid = 0, primed = 0.
REQ-024 Assertion of either reset mid-operation SHALL take effect at the next edge, with any in-flight out_valid suppressed.
REQ-025 rst SHALL have priority over all other inputs.

Structure
REQ-026 Package acc_filter_pkg SHALL hold DEPTH default, LOG2_DEPTH, SUM_W and the FSM state enum {FILL, RUN}.
REQ-027 Per-axis datapath (history, pointer, sum, shift) SHALL be one sub-module acc_avg_axis, instantiated three times; the FSM, fill counter and out_valid/primed live in acc_filter top.
REQ-028 The block SHALL sit directly downstream of acc_wrapper, consuming its x/y/z, done_read and filter_rst.

Verification
REQ-029 DEPTH=8: 8 pulses of x_in=100 -> x_out = 12,25,37,50,62,75,87,100; primed rises with the 8th out_valid.
REQ-030 Constant y_in=-1, 10 pulses -> y_out = -1 every time (floor division); primed=1 from the 8th onward.
REQ-031 Extremes: 8x z_in=32767 -> z_out=32767; then 8x z_in=-32768 -> z_out=-32768; no wrap at any step.
REQ-032 Wrap: 8x x_in=0 then 4x x_in=800 -> x_out = 100,200,300,400 (oldest zeros evicted correctly).
REQ-033 Back-to-back: 16 consecutive sample_valid cycles -> 16 out_valid pulses, each 1 cycle after its input.
REQ-034 filter_rst coincident with the 5th sample_valid -> no out_valid next cycle, outputs = 0, primed = 0; the next sample of 80 gives x_out = 10.

Source files
------------

// File: rtl/acc_filter_pkg.sv
// Shared constants and FSM state type for the accelerometer moving-average filter.
package acc_filter_pkg;

  localparam int DATA_W     = 16;
  localparam int DEPTH_DEF  = 8;
  localparam int LOG2_DEPTH = $clog2(DEPTH_DEF);
  localparam int SUM_W      = DATA_W + LOG2_DEPTH;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } fill_state_e;

endpackage

// File: rtl/acc_filter_if.sv
// Sample/result bundle between the accelerometer front end and the averaging filter.
interface acc_filter_if;
  import acc_filter_pkg::*;

  logic                     sample_valid;
  logic                     filter_rst;
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] y_in;
  logic signed [DATA_W-1:0] z_in;
  logic signed [DATA_W-1:0] x_out;
  logic signed [DATA_W-1:0] y_out;
  logic signed [DATA_W-1:0] z_out;
  logic                     out_valid;
  logic                     primed;

  modport master (
    output sample_valid, filter_rst, x_in, y_in, z_in,
    input  x_out, y_out, z_out, out_valid, primed
  );

  modport slave (
    input  sample_valid, filter_rst, x_in, y_in, z_in,
    output x_out, y_out, z_out, out_valid, primed
  );

endinterface

// File: rtl/acc_avg_axis.sv
// One axis of the moving-average filter: circular history, running sum and
// registered floor-divided average.
module acc_avg_axis
  import acc_filter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [DATA_W-1:0] avg
);

  localparam int LOG2_D = $clog2(DEPTH);
  localparam int SUM_WD = DATA_W + LOG2_D;

  logic signed [DATA_W-1:0] hist_r [DEPTH];
  logic [LOG2_D-1:0]        wr_ptr_r;
  logic signed [SUM_WD-1:0] sum_r;
  logic signed [SUM_WD-1:0] sum_nxt_s;
  logic signed [DATA_W-1:0] avg_r;

  // Running sum after adding the new sample and evicting the oldest entry
  always_comb begin
    sum_nxt_s = sum_r
              + $signed({{LOG2_D{sample[DATA_W-1]}}, sample})
              - $signed({{LOG2_D{hist_r[wr_ptr_r][DATA_W-1]}}, hist_r[wr_ptr_r]});
  end

  // History, write pointer, sum and average registers; the top DATA_W bits
  // of the new sum are the arithmetic-shifted (floor) average
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      sum_r    <= '0;
      avg_r    <= '0;
    end else if (sample_valid) begin
      hist_r[wr_ptr_r] <= sample;
      wr_ptr_r         <= wr_ptr_r + LOG2_D'(1);
      sum_r            <= sum_nxt_s;
      avg_r            <= sum_nxt_s[SUM_WD-1:LOG2_D];
    end
  end

  assign avg = avg_r;

endmodule

// File: rtl/acc_filter.sv
// Three-axis moving-average filter: per-axis datapaths plus the fill/run
// control that produces out_valid and primed.
module acc_filter
  import acc_filter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  acc_filter_if.slave bus
);

  localparam int                LOG2_D    = $clog2(DEPTH);
  localparam int                CNT_W     = LOG2_D + 1;
  localparam logic [CNT_W-1:0]  FILL_LAST = CNT_W'(DEPTH - 1);

  fill_state_e      state_r;
  fill_state_e      state_nxt_s;
  logic [CNT_W-1:0] fill_cnt_r;
  logic [CNT_W-1:0] fill_cnt_nxt_s;
  logic             out_valid_r;
  logic             primed_r;

  // Next-state logic: count accepted samples until the window is full
  always_comb begin
    state_nxt_s    = state_r;
    fill_cnt_nxt_s = fill_cnt_r;
    case (state_r)
      FILL: begin
        if (bus.sample_valid) begin
          fill_cnt_nxt_s = fill_cnt_r + CNT_W'(1);
          if (fill_cnt_r == FILL_LAST) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = FILL;
          end
        end else begin
          fill_cnt_nxt_s = fill_cnt_r;
        end
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = FILL;
    endcase
  end

  // Control registers; a flush beats a coincident sample
  always_ff @(posedge clk) begin
    if (rst || bus.filter_rst) begin
      state_r     <= FILL;
      fill_cnt_r  <= '0;
      out_valid_r <= 1'b0;
      primed_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      fill_cnt_r  <= fill_cnt_nxt_s;
      out_valid_r <= bus.sample_valid;
      primed_r    <= (state_nxt_s == RUN);
    end
  end

  acc_avg_axis #(.DEPTH(DEPTH)) u_axis_x (
    .clk(clk), .rst(rst), .flush(bus.filter_rst), .sample_valid(bus.sample_valid),
    .sample(bus.x_in), .avg(bus.x_out)
  );

  acc_avg_axis #(.DEPTH(DEPTH)) u_axis_y (
    .clk(clk), .rst(rst), .flush(bus.filter_rst), .sample_valid(bus.sample_valid),
    .sample(bus.y_in), .avg(bus.y_out)
  );

  acc_avg_axis #(.DEPTH(DEPTH)) u_axis_z (
    .clk(clk), .rst(rst), .flush(bus.filter_rst), .sample_valid(bus.sample_valid),
    .sample(bus.z_in), .avg(bus.z_out)
  );

  assign bus.out_valid = out_valid_r;
  assign bus.primed    = primed_r;

endmodule
